alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational alu_32 between NREQ requesters (e.g. issue slot and address-gen unit).
//  Accepts requests over a valid/ready handshake and arbitrates them round-robin.
//  Drives the ALU operands and opcode from registers, then samples alu_out after ALU_LAT cycles.
//  Returns the result over a per-requester valid/ready response channel. One operation in flight.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  WIDTH    32  operand/result width
//  OPW      6   opcode width
//  ALU_LAT  1   settle cycles allowed for alu_out before sampling (>=1)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  req_valid  in   NREQ        requester i has an op pending
//  req_ready  out  NREQ        one-hot; op i accepted this cycle
//  req_a      in   NREQ*WIDTH  operand A, slice i = [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  operand B, same slicing
//  req_op     in   NREQ*OPW    opcode, slice i = [i*OPW +: OPW]
//  rsp_valid  out  NREQ        one-hot; result for requester i is valid
//  rsp_ready  in   NREQ        requester i consumes the result
//  rsp_data   out  WIDTH       result (shared bus, qualified by rsp_valid)
//  rsp_err    out  1           opcode illegal; rsp_data = 0
//  alu_a      out  WIDTH       to alu_32 .A
//  alu_b      out  WIDTH       to alu_32 .B
//  alu_op     out  OPW         to alu_32 .opcode
//  alu_out    in   WIDTH       from alu_32 .out
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
//   alu_a/alu_b/alu_op=0, lat_cnt=0, last_grant=NREQ-1 so requester 0 wins first.
//  Legal opcodes: SLL 000100, SRL 000110, SRA 000111, ADD 100000, SUB 100010, AND 100100, OR 100101,
//   XOR 100110, SEQ 101000, SNE 101001, SLT 101010, SGT 101011, SLE 101100, SGE 101101.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: grant g = first i with req_valid[i], searched from last_grant+1 with wrap.
//   req_ready[g]=1 (combinational, IDLE only); latch a/b/op/g in the same cycle.
//   Legal opcode -> EXEC with lat_cnt=0. Illegal opcode -> RESP with rsp_err=1, rsp_data=0; ALU not driven.
//   No req_valid -> stay in IDLE; req_ready=0.
//  EXEC: alu_a/alu_b/alu_op driven from the latches and held stable. lat_cnt increments each cycle.
//   When lat_cnt==ALU_LAT-1, capture rsp_data<=alu_out, rsp_err<=0, go to RESP.
//  RESP: rsp_valid[g]=1; rsp_data/rsp_err held until rsp_ready[g]. Other requesters' rsp_ready ignored.
//   On handshake: last_grant<=g, go to IDLE. alu_op<=0 on leaving EXEC.
//  Latency: accept at cycle T -> rsp_valid at T+ALU_LAT+1 (legal), T+1 (illegal).
//  Throughput: max 1 op / (ALU_LAT+2) cycles with rsp_ready tied high.
//  Fairness: a requester holding req_valid is granted within NREQ grants.
//  Requests arriving outside IDLE wait; req_valid must hold until req_ready (dropping it is legal, no side effect).
//  Reset mid-operation discards the in-flight op; no response is produced.
// STRUCTURE
//  alu_ops.vh (shared include): OPW, all opcode localparams, legality function is_legal_op(op).
//  Sub-module rr_arb: NREQ-way round-robin picker (req vector, last_grant -> one-hot grant + index).
//  Top: FSM, latency counter, operand/result registers; alu_32 instantiated by the parent, not here.
// TESTING (bench instantiates alu_share_arbiter + alu_32)
//  1. Req0 ADD A=32'h8000_0000 B=1 -> rsp_valid=01 at T+2, rsp_data=32'h8000_0001, rsp_err=0.
//  2. Req0,req1 both valid every cycle, SUB / SRA(A=32'h8000_0000,B=1) -> grants alternate 0,1,0,1;
//     data 7FFF_FFFF / C000_0000.
//  3. Req1 op=6'b111111 -> rsp_valid=10 at T+1, rsp_err=1, rsp_data=0; alu_op stays 0.
//  4. SEQ A=B=5 with rsp_ready low 10 cycles -> rsp_valid/rsp_data=1 stable, req_ready=0 throughout.
//  5. ALU_LAT=3, SLT A=5 B=1 -> rsp_valid at T+4, data 0; alu_a/b/op stable during EXEC.
//  6. rst_n low mid-EXEC -> all outputs 0 immediately; first grant after release goes to req0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing arbiter: opcode encodings, legality check, FSM states.
package alu_share_arbiter_pkg;

  localparam int unsigned AluOpw = 6;

  localparam logic [AluOpw-1:0] OpSll = 6'b000100;
  localparam logic [AluOpw-1:0] OpSrl = 6'b000110;
  localparam logic [AluOpw-1:0] OpSra = 6'b000111;
  localparam logic [AluOpw-1:0] OpAdd = 6'b100000;
  localparam logic [AluOpw-1:0] OpSub = 6'b100010;
  localparam logic [AluOpw-1:0] OpAnd = 6'b100100;
  localparam logic [AluOpw-1:0] OpOr  = 6'b100101;
  localparam logic [AluOpw-1:0] OpXor = 6'b100110;
  localparam logic [AluOpw-1:0] OpSeq = 6'b101000;
  localparam logic [AluOpw-1:0] OpSne = 6'b101001;
  localparam logic [AluOpw-1:0] OpSlt = 6'b101010;
  localparam logic [AluOpw-1:0] OpSgt = 6'b101011;
  localparam logic [AluOpw-1:0] OpSle = 6'b101100;
  localparam logic [AluOpw-1:0] OpSge = 6'b101101;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_e;

  function automatic logic is_legal_op(logic [AluOpw-1:0] op);
    case (op)
      OpSll, OpSrl, OpSra, OpAdd, OpSub, OpAnd, OpOr, OpXor,
      OpSeq, OpSne, OpSlt, OpSgt, OpSle, OpSge: is_legal_op = 1'b1;
      default: is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb.sv
// NREQ-way round-robin picker: searches from last+1 with wrap, returns one-hot grant and index.
module alu_share_arbiter_rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(last) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin accept, registered operands,
// sample after ALU_LAT cycles, return result on a per-requester valid/ready response channel.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPW     = 6,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPW-1:0]        alu_op,
  input  logic [WIDTH-1:0]      alu_out
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  arb_state_e      state_q;
  logic [IW-1:0]   gnt_idx_q;
  logic [IW-1:0]   last_q;
  logic [LW-1:0]   lat_cnt_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;
  logic             op_legal;

  alu_share_arbiter_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  always_comb begin
    sel_a    = req_a[32'(arb_idx) * WIDTH +: WIDTH];
    sel_b    = req_b[32'(arb_idx) * WIDTH +: WIDTH];
    sel_op   = req_op[32'(arb_idx) * OPW +: OPW];
    op_legal = is_legal_op(AluOpw'(sel_op));
  end

  // Ready is only offered while idle so at most one op is ever in flight.
  assign req_ready = (state_q == StIdle) ? arb_gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      last_q    <= IW'(NREQ - 1);
      lat_cnt_q <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            gnt_idx_q <= arb_idx;
            lat_cnt_q <= '0;
            if (op_legal) begin
              alu_a   <= sel_a;
              alu_b   <= sel_b;
              alu_op  <= sel_op;
              state_q <= StExec;
            end else begin
              // Illegal ops never reach the ALU; answer immediately with an error.
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= arb_gnt;
              state_q   <= StResp;
            end
          end
        end
        StExec: begin
          if (lat_cnt_q == LW'(ALU_LAT - 1)) begin
            rsp_data  <= alu_out;
            rsp_err   <= 1'b0;
            rsp_valid <= NREQ'(1) << gnt_idx_q;
            alu_op    <= '0;
            state_q   <= StResp;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready[gnt_idx_q]) begin
            rsp_valid <= '0;
            last_q    <= gnt_idx_q;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (ALU_LAT=1 and 3) each with a behavioural ALU,
// a transaction-level model checked every cycle, and directed scenarios with literal expectations.
module tb_alu_share_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPWD  = 6;

  localparam logic [5:0] SLL = 6'b000100, SRL = 6'b000110, SRA = 6'b000111;
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101, XOR = 6'b100110, SEQ = 6'b101000;
  localparam logic [5:0] SNE = 6'b101001, SLT = 6'b101010, SGT = 6'b101011;
  localparam logic [5:0] SLE = 6'b101100, SGE = 6'b101101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid [2];
  logic [NREQ-1:0]       req_ready [2];
  logic [NREQ*WIDTH-1:0] req_a     [2];
  logic [NREQ*WIDTH-1:0] req_b     [2];
  logic [NREQ*OPWD-1:0]  req_op    [2];
  logic [NREQ-1:0]       rsp_valid [2];
  logic [NREQ-1:0]       rsp_ready [2];
  logic [WIDTH-1:0]      rsp_data  [2];
  logic                  rsp_err   [2];
  logic [WIDTH-1:0]      alu_a     [2];
  logic [WIDTH-1:0]      alu_b     [2];
  logic [OPWD-1:0]       alu_op    [2];
  logic [WIDTH-1:0]      alu_out   [2];

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [5:0] op);
    case (op)
      SLL: return a << b[4:0];
      SRL: return a >> b[4:0];
      SRA: return $unsigned($signed(a) >>> b[4:0]);
      ADD: return a + b;
      SUB: return a - b;
      AND: return a & b;
      OR:  return a | b;
      XOR: return a ^ b;
      SEQ: return {31'b0, a == b};
      SNE: return {31'b0, a != b};
      SLT: return {31'b0, $signed(a) <  $signed(b)};
      SGT: return {31'b0, $signed(a) >  $signed(b)};
      SLE: return {31'b0, $signed(a) <= $signed(b)};
      SGE: return {31'b0, $signed(a) >= $signed(b)};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {SLL, SRL, SRA, ADD, SUB, AND, OR, XOR, SEQ, SNE, SLT, SGT, SLE, SGE};
  endfunction

  function automatic int pick(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  assign alu_out[0] = alu_ref(alu_a[0], alu_b[0], alu_op[0]);
  assign alu_out[1] = alu_ref(alu_a[1], alu_b[1], alu_op[1]);

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPWD), .ALU_LAT(1)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_a     (req_a[0]),
    .req_b     (req_b[0]),
    .req_op    (req_op[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_data  (rsp_data[0]),
    .rsp_err   (rsp_err[0]),
    .alu_a     (alu_a[0]),
    .alu_b     (alu_b[0]),
    .alu_op    (alu_op[0]),
    .alu_out   (alu_out[0])
  );

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPWD), .ALU_LAT(3)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_a     (req_a[1]),
    .req_b     (req_b[1]),
    .req_op    (req_op[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_data  (rsp_data[1]),
    .rsp_err   (rsp_err[1]),
    .alu_a     (alu_a[1]),
    .alu_b     (alu_b[1]),
    .alu_op    (alu_op[1]),
    .alu_out   (alu_out[1])
  );

  // Transaction model: per instance, whether an op is outstanding, cycles left before its
  // response appears, its owner and expected result, and what the ALU port should show.
  int          lat    [2] = '{1, 3};
  bit          m_busy [2];
  bit          m_resp [2];
  int          m_wait [2];
  int          m_own  [2];
  int          m_last [2];
  logic [31:0] m_data [2];
  logic        m_err  [2];
  logic [31:0] m_aa   [2];
  logic [31:0] m_ab   [2];
  logic [5:0]  m_aop  [2];

  always @(negedge clk) begin : model
    int g;
    logic [1:0] erdy;
    logic [1:0] erv;
    logic [31:0] a, b;
    logic [5:0] op;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_resp[i] = 0; m_wait[i] = 0; m_last[i] = NREQ - 1;
        m_aa[i] = '0; m_ab[i] = '0; m_aop[i] = '0;
        chk($sformatf("mdl%0d_rst_rsp_data", i), 64'(rsp_data[i]), 64'h0);
        chk($sformatf("mdl%0d_rst_rsp_err", i), 64'(rsp_err[i]), 64'h0);
      end
      g = m_busy[i] ? -1 : pick(req_valid[i], m_last[i]);
      erdy = '0;
      if (rst_n && g >= 0) erdy[g] = 1'b1;
      erv = '0;
      if (m_resp[i]) erv[m_own[i]] = 1'b1;
      chk($sformatf("mdl%0d_req_ready", i), 64'(req_ready[i]), 64'(erdy));
      chk($sformatf("mdl%0d_rsp_valid", i), 64'(rsp_valid[i]), 64'(erv));
      chk($sformatf("mdl%0d_alu_a", i), 64'(alu_a[i]), 64'(m_aa[i]));
      chk($sformatf("mdl%0d_alu_b", i), 64'(alu_b[i]), 64'(m_ab[i]));
      chk($sformatf("mdl%0d_alu_op", i), 64'(alu_op[i]), 64'(m_aop[i]));
      if (m_resp[i]) begin
        chk($sformatf("mdl%0d_rsp_data", i), 64'(rsp_data[i]), 64'(m_data[i]));
        chk($sformatf("mdl%0d_rsp_err", i), 64'(rsp_err[i]), 64'(m_err[i]));
      end
      // Advance across the coming rising edge.
      if (rst_n) begin
        if (!m_busy[i]) begin
          if (g >= 0) begin
            a  = req_a[i][g*WIDTH +: WIDTH];
            b  = req_b[i][g*WIDTH +: WIDTH];
            op = req_op[i][g*OPWD +: OPWD];
            m_busy[i] = 1; m_own[i] = g;
            if (legal(op)) begin
              m_wait[i] = lat[i]; m_aa[i] = a; m_ab[i] = b; m_aop[i] = op;
              m_data[i] = alu_ref(a, b, op); m_err[i] = 1'b0;
            end else begin
              m_resp[i] = 1; m_data[i] = '0; m_err[i] = 1'b1;
            end
          end
        end else if (m_wait[i] > 0) begin
          m_wait[i]--;
          if (m_wait[i] == 0) begin
            m_resp[i] = 1; m_aop[i] = '0;
          end
        end else if (m_resp[i] && rsp_ready[i][m_own[i]]) begin
          m_resp[i] = 0; m_busy[i] = 0; m_last[i] = m_own[i];
        end
      end
    end
  end

  // Raise a request and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic issue(input int inst, input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op);
    bit got;
    got = 0;
    req_a[inst][r*WIDTH +: WIDTH] = a;
    req_b[inst][r*WIDTH +: WIDTH] = b;
    req_op[inst][r*OPWD +: OPWD]  = op;
    req_valid[inst][r] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (req_ready[inst][r]) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout: inst %0d req %0d got no ready expected ready", inst, r);
    end
    @(posedge clk); #1;
    req_valid[inst][r] = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int grants[$];
    logic [31:0] datas[$];
    bit seen;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = '0; req_a[i] = '0; req_b[i] = '0; req_op[i] = '0; rsp_ready[i] = 2'b11;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: ADD on req0, response two cycles after accept.
    issue(0, 0, 32'h8000_0000, 32'h1, ADD);
    @(negedge clk);
    chk("t1_exec_no_rsp", 64'(rsp_valid[0]), 64'h0);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid[0]), 64'b01);
    chk("t1_rsp_data", 64'(rsp_data[0]), 64'h8000_0001);
    chk("t1_rsp_err", 64'(rsp_err[0]), 64'h0);
    @(posedge clk); #1;

    // 3: illegal opcode on req1, response next cycle with error, ALU untouched.
    issue(0, 1, 32'h1234, 32'h5, 6'b111111);
    @(negedge clk);
    chk("t3_rsp_valid", 64'(rsp_valid[0]), 64'b10);
    chk("t3_rsp_err", 64'(rsp_err[0]), 64'h1);
    chk("t3_rsp_data", 64'(rsp_data[0]), 64'h0);
    chk("t3_alu_op", 64'(alu_op[0]), 64'h0);
    @(posedge clk); #1;

    // 2: both requesters always valid; grants must alternate.
    req_a[0] = {32'h8000_0000, 32'h8000_0000};
    req_b[0] = {32'h1, 32'h1};
    req_op[0] = {SRA, SUB};
    req_valid[0] = 2'b11;
    for (int c = 0; c < 40 && (grants.size() < 4 || datas.size() < 4); c++) begin
      @(negedge clk);
      if (req_ready[0] != 0 && grants.size() < 4) grants.push_back(req_ready[0][1] ? 1 : 0);
      if (rsp_valid[0] != 0) datas.push_back(rsp_data[0]);
      if (grants.size() == 4 && req_valid[0] != 0) begin
        @(posedge clk); #1 req_valid[0] = 2'b00;
      end
    end
    chk("t2_grant_count", 64'(grants.size()), 64'd4);
    chk("t2_rsp_count", 64'(datas.size()), 64'd4);
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("t2_grant%0d", k), 64'(grants[k]), 64'(k % 2));
    for (int k = 0; k < datas.size(); k++)
      chk($sformatf("t2_data%0d", k), 64'(datas[k]), (k % 2 == 0) ? 64'h7FFF_FFFF : 64'hC000_0000);
    @(posedge clk); #1;

    // 4: response back-pressured; result held, no new accept while req1 waits.
    rsp_ready[0] = 2'b00;
    req_a[0][WIDTH +: WIDTH] = 32'h1;
    req_b[0][WIDTH +: WIDTH] = 32'h2;
    req_op[0][OPWD +: OPWD] = ADD;
    req_valid[0][1] = 1'b1;
    issue(0, 0, 32'h5, 32'h5, SEQ);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t4_rsp_valid", 64'(rsp_valid[0]), 64'b01);
      chk("t4_rsp_data", 64'(rsp_data[0]), 64'h1);
      chk("t4_req_ready", 64'(req_ready[0]), 64'h0);
    end
    @(posedge clk); #1 rsp_ready[0] = 2'b11;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[0][1]) seen = 1;
    end
    chk("t4_req1_granted", 64'(seen), 64'h1);
    @(posedge clk); #1 req_valid[0] = 2'b00;
    repeat (4) @(posedge clk); #1;

    // 5: ALU_LAT=3 instance, operands stable through execution.
    issue(1, 0, 32'h5, 32'h1, SLT);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t5_no_rsp", 64'(rsp_valid[1]), 64'h0);
      chk("t5_alu_a", 64'(alu_a[1]), 64'h5);
      chk("t5_alu_b", 64'(alu_b[1]), 64'h1);
      chk("t5_alu_op", 64'(alu_op[1]), 64'(SLT));
    end
    @(negedge clk);
    chk("t5_rsp_valid", 64'(rsp_valid[1]), 64'b01);
    chk("t5_rsp_data", 64'(rsp_data[1]), 64'h0);
    @(posedge clk); #1;

    // 6: reset during execution clears everything at once; req0 wins first afterwards.
    issue(1, 1, 32'h7, 32'h8, ADD);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", 64'(rsp_valid[1]), 64'h0);
    chk("t6_req_ready", 64'(req_ready[1]), 64'h0);
    chk("t6_alu_a", 64'(alu_a[1]), 64'h0);
    chk("t6_alu_b", 64'(alu_b[1]), 64'h0);
    chk("t6_alu_op", 64'(alu_op[1]), 64'h0);
    chk("t6_rsp_data", 64'(rsp_data[1]), 64'h0);
    chk("t6_rsp_err", 64'(rsp_err[1]), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    req_a[1] = {32'h3, 32'h4};
    req_b[1] = {32'h1, 32'h2};
    req_op[1] = {SUB, XOR};
    req_valid[1] = 2'b11;
    @(negedge clk);
    chk("t6_first_grant", 64'(req_ready[1]), 64'b01);
    @(posedge clk); #1 req_valid[1] = 2'b00;
    repeat (8) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
